// File: rtl/toggle_gen_if.sv
// Half-period reload handshake for toggle_gen.
// Master offers hp_in/hp_valid; slave answers with hp_ready.
interface toggle_gen_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] hp_in;
    logic             hp_valid;
    logic             hp_ready;

    modport master (
        output hp_in,
        output hp_valid,
        input  hp_ready
    );

    modport slave (
        input  hp_in,
        input  hp_valid,
        output hp_ready
    );
endinterface

// File: rtl/toggle_gen.sv
// Programmable square-wave source: divides clk to sq_out with edge
// strobes, a wrapping toggle counter and run-time half-period reload.
module toggle_gen #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 1,
    parameter int TCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr_cnt,
    toggle_gen_if.slave       hp_if,
    output logic              sq_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [TCNT_W-1:0] toggle_cnt
);
    localparam logic [CNT_W-1:0] HP_RST =
        (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_hp, w_hp_n;
    logic [CNT_W-1:0]  r_pend, w_pend_n;
    logic              r_pend_v, w_pend_v_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              r_sq, w_sq_n;
    logic              r_rise, w_rise_n;
    logic              r_fall, w_fall_n;
    logic [TCNT_W-1:0] r_tcnt, w_tcnt_n;
    logic              w_xfer, w_bound, w_toggle;
    logic [CNT_W-1:0]  w_hp_load;

    always_comb begin
        w_xfer     = hp_if.hp_valid && !r_pend_v;
        w_hp_load  = (hp_if.hp_in == '0) ? CNT_W'(1) : hp_if.hp_in;
        w_bound    = (r_cnt == r_hp - CNT_W'(1));
        w_state_n  = r_state;
        w_hp_n     = r_hp;
        w_pend_n   = r_pend;
        w_pend_v_n = r_pend_v;
        w_cnt_n    = r_cnt;
        w_sq_n     = r_sq;
        w_rise_n   = 1'b0;
        w_fall_n   = 1'b0;
        w_toggle   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (w_xfer) w_hp_n = w_hp_load;
                if (en) w_state_n = RUN;
            end
            RUN: begin
                if (!en) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                    if (r_sq) begin
                        w_sq_n   = 1'b0;
                        w_fall_n = 1'b1;
                        w_toggle = 1'b1;
                    end
                    // Leaving RUN: a pending or fresh value lands in hp now
                    if (r_pend_v) begin
                        w_hp_n     = r_pend;
                        w_pend_v_n = 1'b0;
                    end else if (w_xfer) begin
                        w_hp_n = w_hp_load;
                    end
                end else begin
                    if (w_bound) begin
                        w_cnt_n  = '0;
                        w_sq_n   = ~r_sq;
                        w_rise_n = ~r_sq;
                        w_fall_n = r_sq;
                        w_toggle = 1'b1;
                        if (r_pend_v) begin
                            w_hp_n     = r_pend;
                            w_pend_v_n = 1'b0;
                        end
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                    if (w_xfer) begin
                        w_pend_n   = w_hp_load;
                        w_pend_v_n = 1'b1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (clr_cnt)       w_tcnt_n = '0;
        else if (w_toggle) w_tcnt_n = r_tcnt + TCNT_W'(1);
        else               w_tcnt_n = r_tcnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hp     <= HP_RST;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_cnt    <= '0;
            r_sq     <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_hp     <= w_hp_n;
            r_pend   <= w_pend_n;
            r_pend_v <= w_pend_v_n;
            r_cnt    <= w_cnt_n;
            r_sq     <= w_sq_n;
            r_rise   <= w_rise_n;
            r_fall   <= w_fall_n;
            r_tcnt   <= w_tcnt_n;
        end
    end

    assign hp_if.hp_ready = !r_pend_v;
    assign sq_out         = r_sq;
    assign rise_pulse     = r_rise;
    assign fall_pulse     = r_fall;
    assign toggle_cnt     = r_tcnt;
endmodule

// File: tb/tb_toggle_gen.sv
// Table-driven bench for toggle_gen with an in-order scoreboard;
// a second instance with a 4-bit toggle counter covers wrap-around.
module tb_toggle_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_cnt;
    logic        sq_out, rise_pulse, fall_pulse;
    logic [15:0] toggle_cnt;
    logic        sq4, rise4, fall4;
    logic [3:0]  tcnt4;

    toggle_gen_if #(.CNT_W(8)) ifm ();
    toggle_gen_if #(.CNT_W(8)) if4 ();

    assign if4.hp_in    = ifm.hp_in;
    assign if4.hp_valid = ifm.hp_valid;

    toggle_gen #(.CNT_W(8), .DEFAULT_HALF(1), .TCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .hp_if(ifm.slave), .sq_out(sq_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .toggle_cnt(toggle_cnt)
    );

    toggle_gen #(.CNT_W(8), .DEFAULT_HALF(1), .TCNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .hp_if(if4.slave), .sq_out(sq4), .rise_pulse(rise4),
        .fall_pulse(fall4), .toggle_cnt(tcnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       vld;
        bit [7:0] hpi;
        bit       clr;
        bit       sq;
        bit       ri;
        bit       fa;
        bit       rdy;
        int       t;
    } vec_t;

    typedef struct packed {
        logic        sq;
        logic        ri;
        logic        fa;
        logic        rdy;
        logic [15:0] t;
        logic [3:0]  t4;
        logic        rdy4;
    } obs_t;

    vec_t tbl1[$];
    vec_t tbl2[$];
    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mk(bit e, bit v, int h, bit c,
                                bit s, bit r, bit f, bit y, int t);
        vec_t x;
        x.en = e; x.vld = v; x.hpi = 8'(h); x.clr = c;
        x.sq = s; x.ri = r; x.fa = f; x.rdy = y; x.t = t;
        return x;
    endfunction

    function automatic obs_t to_obs(vec_t v);
        obs_t o;
        o.sq = v.sq; o.ri = v.ri; o.fa = v.fa; o.rdy = v.rdy;
        o.t = 16'(v.t); o.t4 = 4'(v.t); o.rdy4 = v.rdy;
        return o;
    endfunction

    task automatic check(input string nm, input int idx);
        obs_t g, e;
        g = {sq_out, rise_pulse, fall_pulse, ifm.hp_ready,
             toggle_cnt, tcnt4, if4.hp_ready};
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s[%0d]: scoreboard empty, got %h", nm, idx, g);
            return;
        end
        e = exp_q.pop_front();
        if (g !== e)
            $display("FAIL %s[%0d]: got sq=%b ri=%b fa=%b rdy=%b t=%0d t4=%0d rdy4=%b, want sq=%b ri=%b fa=%b rdy=%b t=%0d t4=%0d rdy4=%b",
                     nm, idx, g.sq, g.ri, g.fa, g.rdy, g.t, g.t4, g.rdy4,
                     e.sq, e.ri, e.fa, e.rdy, e.t, e.t4, e.rdy4);
        else
            passes++;
    endtask

    task automatic apply(input vec_t v, input string nm, input int idx);
        @(negedge clk);
        en           = v.en;
        ifm.hp_valid = v.vld;
        ifm.hp_in    = v.hpi;
        clr_cnt      = v.clr;
        exp_q.push_back(to_obs(v));
        @(posedge clk);
        #1;
        check(nm, idx);
    endtask

    initial begin
        // hp=1 free run: toggles every edge, 4-bit counter wraps at 16
        for (int k = 1; k <= 18; k++) begin
            bit s;
            s = (k >= 2) && (((k - 1) % 2) == 1);
            tbl1.push_back(mk(1, 0, 0, 0, s, (k >= 2) && s,
                              (k >= 2) && !s, 1, k - 1));
        end
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 18));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 18));
        // hp=3 loaded in IDLE: first rise 3 edges after entry, period 6
        tbl1.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 18));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 18));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 18));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 18));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 19));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 19));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 19));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 20));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 20));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 20));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 21));
        // drop en with sq=1, then hp=4 and mid-period reload to 2
        tbl1.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 22));
        tbl1.push_back(mk(0, 1, 4, 0, 0, 0, 0, 1, 22));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 22));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 22));
        tbl1.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 22));
        tbl1.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 22));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 23));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 23));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 24));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 24));
        // transfer on a boundary edge applies one boundary later
        tbl1.push_back(mk(1, 1, 5, 0, 1, 1, 0, 0, 25));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 25));
        // clr wins over a coincident toggle
        tbl1.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0));
        for (int k = 0; k < 4; k++)
            tbl1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl1.push_back(mk(1, 1, 9, 0, 1, 0, 0, 0, 1));
        // after async reset: default hp=1, then hp_in=0 loads as 1
        tbl2.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl2.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl2.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 2));
        tbl2.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 2));
        tbl2.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 2));
        tbl2.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl2.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 3));
        tbl2.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 4));
        tbl2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4));

        rst_n        = 1'b0;
        en           = 1'b0;
        clr_cnt      = 1'b0;
        ifm.hp_valid = 1'b0;
        ifm.hp_in    = '0;
        #3;
        exp_q.push_back(to_obs(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl1.size(); i++)
            apply(tbl1[i], "seq1", i);

        // async reset mid-period with a pending half-period
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(to_obs(mk(0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("async_rst", 0);
        @(negedge clk);
        en           = 1'b0;
        ifm.hp_valid = 1'b0;
        rst_n        = 1'b1;

        for (int i = 0; i < tbl2.size(); i++)
            apply(tbl2[i], "seq2", i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
